// File: rtl/ghost_rng_scheduler_if.sv
// Bundle of ghost request/grant and RNG signals shared by the scheduler
// and the ghost AI side.
interface ghost_rng_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic [7:0]         rnd_in;
    logic               reseed;
    logic               rng_enable;
    logic [NUM_REQ-1:0] ack;
    logic [7:0]         rnd_out;
    logic [1:0]         dir_out;
    logic               busy;

    modport master (
        output req, rnd_in, reseed,
        input  rng_enable, ack, rnd_out, dir_out, busy
    );

    modport slave (
        input  req, rnd_in, reseed,
        output rng_enable, ack, rnd_out, dir_out, busy
    );
endinterface

// File: rtl/ghost_rng_scheduler.sv
// Round-robin scheduler sharing one 8-bit random source among ghost AI
// units. Grants are spaced by a HOLD window so consecutive ghosts see
// different generator steps; the game-start pulse is registered into the
// generator's reseed enable.
module ghost_rng_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int GAP     = 3
) (
    input logic                  clk,
    input logic                  reset,
    ghost_rng_scheduler_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (GAP > 1) ? $clog2(GAP) : 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t GAP_LOAD = cnt_t'(GAP - 1);
    localparam ptr_t LAST_REQ = ptr_t'(NUM_REQ - 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    ptr_t               ptr_q, ptr_d;
    cnt_t               gap_q, gap_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [7:0]         rnd_q, rnd_d;
    logic               rng_en_q;

    logic               found;
    ptr_t               winner;
    ptr_t               cand;
    int unsigned        idx;

    // Round-robin search starting at ptr; wrap is an explicit compare so
    // non-power-of-two requester counts work.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        cand   = ptr_q;
        idx    = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = ptr_t'(idx);
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Next-state logic: grant from IDLE, then count out the HOLD window.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gap_d   = gap_q;
        ack_d   = '0;
        rnd_d   = rnd_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d       = HOLD;
                    ack_d[winner] = 1'b1;
                    rnd_d         = bus.rnd_in;
                    ptr_d         = (winner == LAST_REQ) ? '0 : winner + 1'b1;
                    gap_d         = GAP_LOAD;
                end
            end
            HOLD: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scheduler state and captured outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gap_q   <= '0;
            ack_q   <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gap_q   <= gap_d;
            ack_q   <= ack_d;
            rnd_q   <= rnd_d;
        end
    end

    // Reseed path: one-cycle delayed copy of the game-start pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rng_en_q <= 1'b0;
        end else begin
            rng_en_q <= bus.reseed;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.rnd_out    = rnd_q;
    assign bus.dir_out    = rnd_q[1:0];
    assign bus.rng_enable = rng_en_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ghost_rng_scheduler.sv
// Directed bench for ghost_rng_scheduler: one instance with GAP=3 and one
// with GAP=1, both 4 requesters, sharing clock and reset.
module tb_ghost_rng_scheduler;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    ghost_rng_scheduler_if #(.NUM_REQ(4)) b3 ();
    ghost_rng_scheduler_if #(.NUM_REQ(4)) b1 ();

    ghost_rng_scheduler #(.NUM_REQ(4), .GAP(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (b3.slave)
    );

    ghost_rng_scheduler #(.NUM_REQ(4), .GAP(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One grant on the GAP=3 instance: ack next cycle, requester drops,
    // then three HOLD cycles in total before IDLE.
    task automatic issue(input logic [3:0] exp, input logic [7:0] rnd, input string tag);
        b3.rnd_in = rnd;
        tick();
        chk({tag, "_ack"},  32'(b3.ack), 32'(exp));
        chk({tag, "_rnd"},  32'(b3.rnd_out), 32'(rnd));
        chk({tag, "_dir"},  32'(b3.dir_out), 32'(rnd[1:0]));
        chk({tag, "_busy1"}, 32'(b3.busy), 32'd1);
        b3.req = b3.req & ~exp;
        tick();
        chk({tag, "_ack_off"}, 32'(b3.ack), 32'd0);
        chk({tag, "_busy2"}, 32'(b3.busy), 32'd1);
        tick();
        chk({tag, "_busy3"}, 32'(b3.busy), 32'd1);
        tick();
        chk({tag, "_idle"}, 32'(b3.busy), 32'd0);
        chk({tag, "_ack_idle"}, 32'(b3.ack), 32'd0);
        chk({tag, "_rnd_hold"}, 32'(b3.rnd_out), 32'(rnd));
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        reset    = 1'b1;
        b3.req   = '0;
        b3.rnd_in = 8'h00;
        b3.reseed = 1'b0;
        b1.req   = '0;
        b1.rnd_in = 8'h00;
        b1.reseed = 1'b0;
        tick();
        tick();
        chk("rst_ack",  32'(b3.ack), 32'd0);
        chk("rst_busy", 32'(b3.busy), 32'd0);
        chk("rst_rnd",  32'(b3.rnd_out), 32'd0);
        chk("rst_rngen", 32'(b3.rng_enable), 32'd0);
        reset = 1'b0;

        // 1: async reset while ack is high mid-HOLD
        b3.req    = 4'b0001;
        b3.rnd_in = 8'h5A;
        b3.reseed = 1'b1;
        tick();
        chk("t1_ack",   32'(b3.ack), 32'h1);
        chk("t1_rnd",   32'(b3.rnd_out), 32'h5A);
        chk("t1_rngen", 32'(b3.rng_enable), 32'd1);
        chk("t1_busy",  32'(b3.busy), 32'd1);
        b3.reseed = 1'b0;
        reset = 1'b1;
        #1;
        chk("t1_async_ack",   32'(b3.ack), 32'd0);
        chk("t1_async_busy",  32'(b3.busy), 32'd0);
        chk("t1_async_rnd",   32'(b3.rnd_out), 32'd0);
        chk("t1_async_dir",   32'(b3.dir_out), 32'd0);
        chk("t1_async_rngen", 32'(b3.rng_enable), 32'd0);
        tick();
        chk("t1_inrst_ack", 32'(b3.ack), 32'd0);
        reset = 1'b0;
        issue(4'b0001, 8'h5A, "t1_rearb");

        // 2: single request, ptr 1 -> grant 2, ptr becomes 3
        b3.req = 4'b0100;
        issue(4'b0100, 8'hB6, "t2_single");
        b3.req = 4'b1111;
        issue(4'b1000, 8'h27, "t2_ptr3");
        b3.req = 4'b0000;

        // 4: wrap and skip from ptr 3
        b3.req = 4'b0100;
        issue(4'b0100, 8'h91, "t4_setup");
        b3.req = 4'b0011;
        issue(4'b0001, 8'h4D, "t4_wrap0");
        issue(4'b0010, 8'hE2, "t4_then1");
        b3.req = 4'b1000;
        issue(4'b1000, 8'h13, "t4_grant3");

        // 3: round-robin fairness, two passes starting at 0
        b3.req = 4'b1111;
        issue(4'b0001, 8'hA0, "t3_p1_r0");
        issue(4'b0010, 8'hA1, "t3_p1_r1");
        issue(4'b0100, 8'hA2, "t3_p1_r2");
        issue(4'b1000, 8'hA3, "t3_p1_r3");
        chk("t3_all_dropped", 32'(b3.req), 32'd0);
        b3.req = 4'b1111;
        issue(4'b0001, 8'hC4, "t3_p2_r0");
        issue(4'b0010, 8'hC5, "t3_p2_r1");
        issue(4'b0100, 8'hC6, "t3_p2_r2");
        issue(4'b1000, 8'hC7, "t3_p2_r3");

        // 6: reseed coincident with a grant, then a 2-cycle reseed
        b3.req    = 4'b0010;
        b3.reseed = 1'b1;
        b3.rnd_in = 8'h3C;
        tick();
        chk("t6_rngen", 32'(b3.rng_enable), 32'd1);
        chk("t6_ack",   32'(b3.ack), 32'h2);
        chk("t6_rnd",   32'(b3.rnd_out), 32'h3C);
        chk("t6_dir",   32'(b3.dir_out), 32'd0);
        b3.reseed = 1'b0;
        b3.req    = 4'b0000;
        tick();
        chk("t6_rngen_off", 32'(b3.rng_enable), 32'd0);
        b3.reseed = 1'b1;
        tick();
        chk("t6_two_a", 32'(b3.rng_enable), 32'd1);
        tick();
        chk("t6_two_b", 32'(b3.rng_enable), 32'd1);
        b3.reseed = 1'b0;
        tick();
        chk("t6_two_off", 32'(b3.rng_enable), 32'd0);
        tick();
        chk("t6_idle", 32'(b3.busy), 32'd0);

        // 5: GAP=1, requester 0 drops after its ack, requester 1 held
        b1.req    = 4'b0011;
        b1.rnd_in = 8'h66;
        tick();
        chk("t5_ack0",  32'(b1.ack), 32'h1);
        chk("t5_busy0", 32'(b1.busy), 32'd1);
        chk("t5_rnd0",  32'(b1.rnd_out), 32'h66);
        b1.req    = 4'b0010;
        b1.rnd_in = 8'h7B;
        tick();
        chk("t5_gap_ack",  32'(b1.ack), 32'd0);
        chk("t5_gap_busy", 32'(b1.busy), 32'd0);
        tick();
        chk("t5_ack1", 32'(b1.ack), 32'h2);
        chk("t5_rnd1", 32'(b1.rnd_out), 32'h7B);
        chk("t5_dir1", 32'(b1.dir_out), 32'd3);
        b1.req = 4'b0000;
        tick();
        chk("t5_after_ack", 32'(b1.ack), 32'd0);
        tick();
        chk("t5_no_regrant", 32'(b1.ack), 32'd0);
        chk("t5_idle", 32'(b1.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
